// File: rtl/uart_tx_buffer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer_if
// Bundles the byte-producer side and the status side of the debug UART
// transmit buffer.
//   dataIn         byte to enqueue
//   writeFifoFlag  enqueue dataIn this cycle (one byte per high cycle)
//   holdTrans      1 = do not start a new byte (an in-flight byte completes)
//   tx             serial line, idles high
//   uartDataSent   one-cycle pulse at the end of each byte's stop bit
//   fifoFull       queued byte count == depth
//   fifoEmpty      queued byte count == 0
//   fifoCount      bytes queued (excludes the byte being serialized)
//   overflow       sticky: a write was attempted while full
// Modports: master = byte producer (debug unit), slave = uart_tx_buffer.
// ---------------------------------------------------------------------------
interface uart_tx_buffer_if #(
    parameter int ADDR_BITS = 4
);
    logic [7:0]         dataIn;
    logic               writeFifoFlag;
    logic               holdTrans;
    logic               tx;
    logic               uartDataSent;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [ADDR_BITS:0] fifoCount;
    logic               overflow;

    modport master (
        output dataIn, writeFifoFlag, holdTrans,
        input  tx, uartDataSent, fifoFull, fifoEmpty, fifoCount, overflow
    );

    modport slave (
        input  dataIn, writeFifoFlag, holdTrans,
        output tx, uartDataSent, fifoFull, fifoEmpty, fifoCount, overflow
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
// Transmit side of the debug UART link: a byte FIFO feeding an 8N1
// serializer (start bit, 8 data bits LSB first, one stop bit).
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   bus    uart_tx_buffer_if.slave (byte input, hold, serial line, status)
// Parameters:
//   ADDR_BITS     FIFO address width, depth = 2**ADDR_BITS bytes
//   CLKS_PER_BIT  clock cycles per UART bit (must be >= 2)
// ---------------------------------------------------------------------------
module uart_tx_buffer #(
    parameter int ADDR_BITS    = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            clock,
    input  logic            reset,
    uart_tx_buffer_if.slave bus
);
    localparam int DEPTH  = 1 << ADDR_BITS;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]  BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]  BAUD_PRELAST = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [ADDR_BITS:0] FULL_COUNT   = (ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [7:0]           mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic                 full_q;
    logic                 empty_q;
    logic                 overflow_q;
    logic [7:0]           shift;
    logic [BAUD_W-1:0]    baud;
    logic [2:0]           bit_idx;
    logic                 tx_q;
    logic                 sent_q;
    logic                 pop;
    logic                 push;

    // Pop decision uses the registered empty flag, so a byte written into an
    // empty FIFO cannot be popped on the same edge (no bypass path).
    assign pop  = (state == IDLE) && !empty_q && !bus.holdTrans;
    // A write while full is still accepted when the same edge pops a byte.
    assign push = bus.writeFifoFlag && (!full_q || pop);

    // FIFO pointers, occupancy and flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (bus.writeFifoFlag && !push) overflow_q <= 1'b1;
            case ({push, pop})
                2'b10: begin
                    count   <= count + 1'b1;
                    full_q  <= (count == FULL_COUNT - 1'b1);
                    empty_q <= 1'b0;
                end
                2'b01: begin
                    count   <= count - 1'b1;
                    full_q  <= 1'b0;
                    empty_q <= (count == 1);
                end
                default: ;
            endcase
        end
    end

    // FIFO storage and shift register are pure data: no reset
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.dataIn;
    end

    always_ff @(posedge clock) begin
        if (pop)
            shift <= mem[rd_ptr];
        else if (state == DATA && baud == BAUD_LAST)
            shift <= shift >> 1;
    end

    // Serializer FSM; tx and uartDataSent are registered so the line never
    // glitches. tx for the next bit is loaded on the boundary edge, hence the
    // look-ahead to shift[1] while shift itself moves right on that edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            tx_q    <= 1'b1;
            sent_q  <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state <= START;
                        tx_q  <= 1'b0;
                        baud  <= '0;
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_q    <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                        // Raised one edge early so the registered pulse lands
                        // on the final stop-bit cycle.
                        sent_q <= (baud == BAUD_PRELAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx           = tx_q;
    assign bus.uartDataSent = sent_q;
    assign bus.fifoFull     = full_q;
    assign bus.fifoEmpty    = empty_q;
    assign bus.fifoCount    = count;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffer
// Directed and randomized stimulus for uart_tx_buffer (CLKS_PER_BIT=4,
// ADDR_BITS=2). A queue of accepted bytes serves as the reference; each frame
// is compared cycle by cycle against the 8N1 waveform built from that byte.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffer;
    localparam int CPB   = 4;
    localparam int AB    = 2;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] mq[$];

    uart_tx_buffer_if #(.ADDR_BITS(AB)) bus ();

    uart_tx_buffer #(
        .ADDR_BITS   (AB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accept);
        bus.dataIn        = b;
        bus.writeFifoFlag = 1'b1;
        if (accept) mq.push_back(b);
        @(negedge clk);
        bus.writeFifoFlag = 1'b0;
    endtask

    // Waits (bounded) for the start bit, then checks the whole frame against
    // the next expected byte. Returns at the negedge of the last stop cycle.
    task automatic expect_next(input int max_wait);
        logic [7:0] b;
        logic       exp_tx;
        int         w = 0;
        while (bus.tx !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        chk("frame_start", bus.tx, 1'b0);
        if (mq.size() == 0) begin
            chk("model_queue_nonempty", 32'd0, 32'd1);
            b = 8'h00;
        end else begin
            b = mq.pop_front();
        end
        for (int i = 0; i < FRAME; i++) begin
            if (i < CPB)             exp_tx = 1'b0;
            else if (i < 9 * CPB)    exp_tx = b[(i - CPB) / CPB];
            else                     exp_tx = 1'b1;
            chk($sformatf("frame_%02h_tx_c%0d", b, i + 1), bus.tx, exp_tx);
            chk($sformatf("frame_%02h_sent_c%0d", b, i + 1), bus.uartDataSent, (i == FRAME - 1));
            if (i != FRAME - 1) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst_n             = 1'b0;
        bus.dataIn        = 8'h00;
        bus.writeFifoFlag = 1'b0;
        bus.holdTrans     = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_sent", bus.uartDataSent, 1'b0);
        chk("rst_full", bus.fifoFull, 1'b0);
        chk("rst_empty", bus.fifoEmpty, 1'b1);
        chk("rst_count", bus.fifoCount, 0);
        chk("rst_ovf", bus.overflow, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0x35, exact latency
        write_byte(8'h35, 1'b1);
        chk("t2_count1", bus.fifoCount, 1);
        chk("t2_notempty", bus.fifoEmpty, 1'b0);
        chk("t2_tx_idle_nobypass", bus.tx, 1'b1);
        @(negedge clk);
        chk("t2_count0_after_pop", bus.fifoCount, 0);
        expect_next(0);
        @(negedge clk);
        chk("t2_sent_drop", bus.uartDataSent, 1'b0);
        chk("t2_empty_after", bus.fifoEmpty, 1'b1);
        chk("t2_tx_high_after", bus.tx, 1'b1);

        // Hold, fill, overflow, release
        bus.holdTrans = 1'b1;
        for (int k = 0; k < 4; k++) write_byte(8'h30 + 8'(k), 1'b1);
        chk("t3_count4", bus.fifoCount, 4);
        chk("t3_full", bus.fifoFull, 1'b1);
        chk("t3_ovf0", bus.overflow, 1'b0);
        chk("t3_tx_held", bus.tx, 1'b1);
        write_byte(8'h34, 1'b0);
        chk("t3_ovf1", bus.overflow, 1'b1);
        chk("t3_count_stays4", bus.fifoCount, 4);
        repeat (5) @(negedge clk);
        chk("t3_tx_still_held", bus.tx, 1'b1);
        bus.holdTrans = 1'b0;
        for (int k = 0; k < 4; k++) expect_next(4);
        @(negedge clk);
        chk("t3_empty_after", bus.fifoEmpty, 1'b1);
        chk("t3_ovf_sticky", bus.overflow, 1'b1);

        // Reset in the middle of a frame
        write_byte(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        chk("t1_midframe_low", bus.tx, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t1_tx", bus.tx, 1'b1);
        chk("t1_empty", bus.fifoEmpty, 1'b1);
        chk("t1_count", bus.fifoCount, 0);
        chk("t1_sent", bus.uartDataSent, 1'b0);
        chk("t1_ovf_cleared", bus.overflow, 1'b0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_tx_idle_after", bus.tx, 1'b1);

        // Full FIFO with write on the pop edge
        bus.holdTrans = 1'b1;
        for (int k = 0; k < 4; k++) write_byte(8'h61 + 8'(k), 1'b1);
        chk("t4_full", bus.fifoFull, 1'b1);
        bus.holdTrans = 1'b0;
        write_byte(8'h65, 1'b1);
        chk("t4_count_stays4", bus.fifoCount, 4);
        chk("t4_full_kept", bus.fifoFull, 1'b1);
        chk("t4_ovf0", bus.overflow, 1'b0);
        expect_next(0);
        for (int k = 0; k < 4; k++) expect_next(4);
        @(negedge clk);
        chk("t4_empty_after", bus.fifoEmpty, 1'b1);

        // Pointer wrap with spaced writes
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    write_byte(8'h41 + 8'(k), 1'b1);
                    chk("t5_count_le3", (bus.fifoCount <= 3), 1'b1);
                    repeat (19) @(negedge clk);
                end
            end
            begin
                for (int k = 0; k < 6; k++) expect_next(30);
            end
        join
        @(negedge clk);
        chk("t5_ovf0", bus.overflow, 1'b0);
        chk("t5_empty", bus.fifoEmpty, 1'b1);

        // Hold raised mid-DATA: current frame completes, next byte waits
        write_byte(8'h55, 1'b1);
        write_byte(8'h77, 1'b1);
        fork
            expect_next(0);
            begin
                repeat (12) @(negedge clk);
                bus.holdTrans = 1'b1;
            end
        join
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t6_tx_held", bus.tx, 1'b1);
            chk("t6_no_pulse", bus.uartDataSent, 1'b0);
            chk("t6_count1", bus.fifoCount, 1);
        end
        bus.holdTrans = 1'b0;
        expect_next(4);
        @(negedge clk);
        chk("t6_empty", bus.fifoEmpty, 1'b1);

        // Randomized bursts under hold
        for (int r = 0; r < 4; r++) begin
            bus.holdTrans = 1'b1;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) write_byte(8'($urandom), 1'b1);
            chk("rnd_count", bus.fifoCount, n);
            chk("rnd_full", bus.fifoFull, (n == 4));
            chk("rnd_empty", bus.fifoEmpty, 1'b0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            bus.holdTrans = 1'b0;
            for (int k = 0; k < n; k++) expect_next(10);
            @(negedge clk);
            chk("rnd_empty_after", bus.fifoEmpty, 1'b1);
        end
        chk("final_ovf", bus.overflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
